// File: rtl/ah_decode_sched.sv
// Shared range decoder behind a round-robin arbiter: one field per 3 cycles, registered lookup.
// Optional saturating decode-error counter is built only when AH_DEC_ERR_CNT_EN is defined.
module ah_decode_sched #(
    parameter int NUM_REQ    = 4,
    parameter int REQ_W      = 2,
    parameter int FIELD_W    = 12,
    parameter int NUM_CLIENT = 8,
    parameter int CLIENT_W   = 3
) (
    input  logic                       clk,
    input  logic                       rst_n,
    input  logic [NUM_REQ-1:0]         req_valid,
    input  logic [NUM_REQ*FIELD_W-1:0] req_field,
    output logic [NUM_REQ-1:0]         req_ready,
    input  logic                       cfg_wr,
    input  logic [CLIENT_W-1:0]        cfg_idx,
    input  logic [FIELD_W-1:0]         cfg_lo,
    input  logic [FIELD_W-1:0]         cfg_hi,
    input  logic                       cfg_en,
    output logic                       resp_valid,
    input  logic                       resp_ready,
    output logic [REQ_W-1:0]           resp_req_id,
    output logic [CLIENT_W-1:0]        resp_client,
    output logic                       resp_err,
    output logic [15:0]                err_cnt
);

    typedef enum logic [1:0] {IDLE, LOOKUP, RESP} state_t;

    state_t                                state_q;
    logic [REQ_W-1:0]                      rr_ptr_q;
    logic [REQ_W-1:0]                      id_q;
    logic [FIELD_W-1:0]                    field_q;
    logic [NUM_CLIENT-1:0][FIELD_W-1:0]    lo_q;
    logic [NUM_CLIENT-1:0][FIELD_W-1:0]    hi_q;
    logic [NUM_CLIENT-1:0]                 en_q;
    logic                                  resp_valid_q;
    logic [REQ_W-1:0]                      resp_req_id_q;
    logic [CLIENT_W-1:0]                   resp_client_q;
    logic                                  resp_err_q;

    logic                                  grant_vld_d;
    logic [REQ_W-1:0]                      grant_id_d;
    logic                                  match_hit_d;
    logic [CLIENT_W-1:0]                   match_idx_d;

    // Scan from rr_ptr upward with wrap; walking offsets downward lets the nearest one win.
    always_comb begin
        int s;
        s           = 0;
        grant_vld_d = 1'b0;
        grant_id_d  = '0;
        for (int i = NUM_REQ - 1; i >= 0; i--) begin
            s = int'(rr_ptr_q) + i;
            if (s >= NUM_REQ) begin
                s = s - NUM_REQ;
            end
            if (req_valid[REQ_W'(s)]) begin
                grant_vld_d = 1'b1;
                grant_id_d  = REQ_W'(s);
            end
        end
    end

    // Lowest enabled window containing the latched field wins.
    always_comb begin
        match_hit_d = 1'b0;
        match_idx_d = '0;
        for (int k = NUM_CLIENT - 1; k >= 0; k--) begin
            if (en_q[CLIENT_W'(k)] && (lo_q[CLIENT_W'(k)] <= field_q) &&
                (field_q <= hi_q[CLIENT_W'(k)])) begin
                match_hit_d = 1'b1;
                match_idx_d = CLIENT_W'(k);
            end
        end
    end

    // Valid/ready: a transfer happens on any edge where valid and ready are both high;
    // the producer holds its payload stable until that edge.
    assign req_ready = (rst_n && (state_q == IDLE) && grant_vld_d) ?
                       (NUM_REQ'(1) << grant_id_d) : '0;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q       <= IDLE;
            rr_ptr_q      <= '0;
            id_q          <= '0;
            field_q       <= '0;
            lo_q          <= '0;
            hi_q          <= '0;
            en_q          <= '0;
            resp_valid_q  <= 1'b0;
            resp_req_id_q <= '0;
            resp_client_q <= '0;
            resp_err_q    <= 1'b0;
        end else begin
            if (cfg_wr) begin
                lo_q[cfg_idx] <= cfg_lo;
                hi_q[cfg_idx] <= cfg_hi;
                en_q[cfg_idx] <= cfg_en;
            end
            case (state_q)
                IDLE: begin
                    if (grant_vld_d) begin
                        field_q <= req_field[grant_id_d*FIELD_W +: FIELD_W];
                        id_q    <= grant_id_d;
                        state_q <= LOOKUP;
                    end
                end
                LOOKUP: begin
                    resp_valid_q  <= 1'b1;
                    resp_req_id_q <= id_q;
                    resp_client_q <= match_hit_d ? match_idx_d : '0;
                    resp_err_q    <= ~match_hit_d;
                    state_q       <= RESP;
                end
                RESP: begin
                    if (resp_ready) begin
                        resp_valid_q <= 1'b0;
                        rr_ptr_q     <= (id_q == REQ_W'(NUM_REQ - 1)) ? '0 : id_q + 1'b1;
                        state_q      <= IDLE;
                    end
                end
                default: state_q <= IDLE;
            endcase
        end
    end

    assign resp_valid  = resp_valid_q;
    assign resp_req_id = resp_req_id_q;
    assign resp_client = resp_client_q;
    assign resp_err    = resp_err_q;

`ifdef AH_DEC_ERR_CNT_EN
    logic [15:0] err_cnt_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            err_cnt_q <= '0;
        end else if ((state_q == LOOKUP) && !match_hit_d && (err_cnt_q != 16'hFFFF)) begin
            err_cnt_q <= err_cnt_q + 16'd1;
        end
    end

    assign err_cnt = err_cnt_q;
`else
    assign err_cnt = 16'h0000;
`endif

endmodule

// File: doc/ah_decode_sched.md
Name: ah_decode_sched

Overview:
Shared-decoder scheduler for the AH ingress path. NUM_REQ requesters each present a FIELD_W-bit packet field. A round-robin arbiter admits one field at a time into a single registered range decoder. The decoder compares the field against a software-programmed table of NUM_CLIENT inclusive [lo,hi] windows and returns the client index or a decode error to the winning requester over a valid/ready response channel.

Parameters:
NUM_REQ, 4, number of requesters (2..8)
REQ_W, 2, requester id width, equal to clog2(NUM_REQ)
FIELD_W, 12, width of the ingress packet field and of the range bounds
NUM_CLIENT, 8, number of decode table entries
CLIENT_W, 3, client index width, equal to clog2(NUM_CLIENT)

Ports:
clk  in  1  sole clock, rising edge
rst_n  in  1  asynchronous active-low reset
req_valid  in  NUM_REQ  per-requester field-valid
req_field  in  NUM_REQ*FIELD_W  packed fields; requester i occupies [i*FIELD_W +: FIELD_W]
req_ready  out  NUM_REQ  one-hot accept strobe to the arbitration winner
cfg_wr  in  1  table write strobe
cfg_idx  in  CLIENT_W  table entry being written
cfg_lo  in  FIELD_W  inclusive lower bound
cfg_hi  in  FIELD_W  inclusive upper bound
cfg_en  in  1  entry enable
resp_valid  out  1  decode result valid
resp_ready  in  1  downstream accepts result
resp_req_id  out  REQ_W  requester that owns the result
resp_client  out  CLIENT_W  matched client index
resp_err  out  1  no enabled entry matched
err_cnt  out  16  decode-error count (see Optional Feature)

Behaviour:
- Reset (async assert, sync deassert by design): state=IDLE, rr_ptr=0, req_ready=0, resp_valid=0, resp_req_id=0, resp_client=0, resp_err=0, err_cnt=0. All table entries are reset to lo=0, hi=0, en=0.
- FSM states: IDLE, LOOKUP, RESP.
- IDLE: if any req_valid is high, select the winner as the first requester with req_valid high, searching from rr_ptr upward and wrapping at NUM_REQ. Pulse req_ready[winner] for exactly this cycle. Latch the winner's field and id, then go to LOOKUP. With no req_valid, remain in IDLE and keep req_ready=0.
- Handshake: a transfer occurs when req_valid[i] and req_ready[i] are both high. Requesters hold valid and field until accepted. req_ready is never high outside IDLE.
- LOOKUP (1 cycle): entry k matches when en[k]=1 and lo[k] <= field <= hi[k]. Comparisons are unsigned FIELD_W bits. If several entries match, the lowest k wins. On a match, register resp_client=k and resp_err=0. With no match, register resp_client=0 and resp_err=1. Set resp_valid=1 and go to RESP.
- An entry with lo > hi never matches. An entry with lo == hi matches exactly one value.
- RESP: hold resp_valid and all resp_* fields stable until resp_ready is high. On that edge, clear resp_valid, set rr_ptr = (winner+1) mod NUM_REQ, and go to IDLE.
- Throughput: one decode per 3 cycles minimum. Latency from accept edge to resp_valid is 2 cycles.
- Config: cfg_wr updates entry cfg_idx at the clock edge. A write is accepted in any state.
- A lookup in the same cycle as a write to the matched entry uses the pre-write table values.
- Reset mid-operation: any in-flight request is dropped with no response. Requesters re-present after reset.
- A request whose req_valid drops before it is accepted is simply not served. No error is raised.

Optional Feature:
Macro AH_DEC_ERR_CNT_EN.
- Defined: err_cnt increments by 1 on every LOOKUP cycle that yields resp_err=1. It saturates at 16'hFFFF and clears only on reset.
- Undefined: no counter logic is built and err_cnt is tied to 16'h0000.

Test Plan:
- Reset, then entry0 = {lo=12'h000, hi=12'h0FF, en=1}; requester 2 sends field 12'h0A5 -> req_ready=4'b0100 for one cycle; 2 cycles later resp_valid=1, resp_req_id=2, resp_client=0, resp_err=0.
- Overlap: entry1 = {12'h100, 12'h3FF, 1}, entry3 = {12'h200, 12'h2FF, 1}; field 12'h250 -> resp_client=1 (lowest index wins). Field 12'h3FF -> client 1 (inclusive upper bound).
- No match: all entries disabled after reset; field 12'h7FF -> resp_err=1, resp_client=0. With AH_DEC_ERR_CNT_EN defined, err_cnt=1 after this request, and 3 after three such requests.
- Fairness: all 4 req_valid held high with resp_ready=1 -> grant order 0,1,2,3,0 on consecutive transactions, with no requester skipped.
- Backpressure: resp_ready=0 for 10 cycles in RESP -> resp_* stable, req_ready stays 0 and no new grant occurs. When resp_ready=1, the next grant follows in IDLE one cycle later.
- Config race and reset: write entry0 to {12'h800, 12'h8FF, 1} in the LOOKUP cycle of field 12'h050, with old entry0 = 0..0FF -> result is client 0. Assert rst_n=0 in RESP -> resp_valid drops to 0 immediately and the table is cleared.
